// File: rtl/stopwatch_controller_pkg.sv
// Shared definitions for the stopwatch controller slice.
//   - FSM state encodings (IDLE/RUN/LAP/STOP), also visible on the state output.
//   - Default button lockout length in 100 Hz ticks.
//   - Saturating lap-count increment helper.
package stopwatch_controller_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_LAP  = 2'b10;
  localparam logic [1:0] ST_STOP = 2'b11;

  // 20 ticks at 100 Hz = 200 ms of button lockout after an accepted event.
  localparam logic [7:0] LOCKOUT_TICKS_DEFAULT = 8'd20;

  localparam logic [3:0] LAP_COUNT_MAX = 4'd15;

  // Lap counter holds at its maximum instead of wrapping.
  function automatic logic [3:0] lap_count_inc(input logic [3:0] cnt);
    return (cnt == LAP_COUNT_MAX) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_controller_if.sv
// Button/tick inputs and control outputs of the stopwatch controller.
//   tick           : one-cycle 100 Hz pulse
//   btn_start_stop : debounced start/stop level
//   btn_lap_reset  : debounced lap/reset level
//   run            : time counter enable
//   clear          : one-cycle counter clear pulse
//   freeze         : display shows latched lap value
//   lap_capture    : one-cycle lap latch pulse
//   lap_count      : laps since last clear (saturates at 15)
//   state          : FSM state encoding
// Modport slave is the controller side, master is the driver/observer side.
interface stopwatch_controller_if;
  logic       tick;
  logic       btn_start_stop;
  logic       btn_lap_reset;
  logic       run;
  logic       clear;
  logic       freeze;
  logic       lap_capture;
  logic [3:0] lap_count;
  logic [1:0] state;

  modport slave (
    input  tick, btn_start_stop, btn_lap_reset,
    output run, clear, freeze, lap_capture, lap_count, state
  );

  modport master (
    output tick, btn_start_stop, btn_lap_reset,
    input  run, clear, freeze, lap_capture, lap_count, state
  );
endinterface

// File: rtl/stopwatch_controller_event_filter.sv
// sw_event_filter: rising-edge detection and post-event lockout for both
// stopwatch buttons.
//   clk_ms, reset_n          : clock, async active-low reset
//   tick                     : 100 Hz pulse that paces the lockout countdown
//   btn_start_stop/lap_reset : debounced button levels
//   ss_evt, lr_evt           : one-cycle accepted events (start/stop wins a tie)
// The event outputs are combinational so the controller registers react on
// the same edge that samples the button rising.
module sw_event_filter
  import stopwatch_controller_pkg::*;
#(
  parameter logic [7:0] LOCKOUT_TICKS = LOCKOUT_TICKS_DEFAULT
) (
  input  logic clk_ms,
  input  logic reset_n,
  input  logic tick,
  input  logic btn_start_stop,
  input  logic btn_lap_reset,
  output logic ss_evt,
  output logic lr_evt
);

  logic       ss_prev;
  logic       lr_prev;
  logic [7:0] lock_cnt;
  logic       ss_rise;
  logic       lr_rise;
  logic       unlocked;
  logic       accept;

  assign ss_rise  = btn_start_stop & ~ss_prev;
  assign lr_rise  = btn_lap_reset  & ~lr_prev;
  assign unlocked = (lock_cnt == 8'd0);

  // A simultaneous lap/reset rise is dropped in favour of start/stop.
  assign ss_evt = ss_rise & unlocked;
  assign lr_evt = lr_rise & ~ss_rise & unlocked;
  assign accept = ss_evt | lr_evt;

  // Previous samples track the buttons every cycle, even while locked out,
  // so a press made during lockout is not replayed once it expires.
  always_ff @(posedge clk_ms or negedge reset_n) begin
    if (!reset_n) begin
      ss_prev <= 1'b0;
      lr_prev <= 1'b0;
    end else begin
      ss_prev <= btn_start_stop;
      lr_prev <= btn_lap_reset;
    end
  end

  // Load takes priority, so a tick coinciding with the load is ignored.
  always_ff @(posedge clk_ms or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt <= 8'd0;
    end else if (accept) begin
      lock_cnt <= LOCKOUT_TICKS;
    end else if (tick && !unlocked) begin
      lock_cnt <= lock_cnt - 8'd1;
    end
  end

endmodule

// File: rtl/stopwatch_controller.sv
// stopwatch_controller: start/stop/lap/reset FSM for a 100 Hz stopwatch.
//   clk_ms  : master clock
//   reset_n : asynchronous active-low reset
//   bus     : stopwatch_controller_if.slave (buttons, tick, control outputs)
// All outputs are registered from the next-state decode so they change on the
// same edge that accepts a button event.
module stopwatch_controller
  import stopwatch_controller_pkg::*;
#(
  parameter logic [7:0] LOCKOUT_TICKS = LOCKOUT_TICKS_DEFAULT
) (
  input  logic                  clk_ms,
  input  logic                  reset_n,
  stopwatch_controller_if.slave bus
);

  logic       ss_evt;
  logic       lr_evt;
  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [3:0] lap_cnt_q;
  logic [3:0] lap_cnt_d;
  logic       clear_q;
  logic       clear_d;
  logic       cap_q;
  logic       cap_d;
  logic       run_q;
  logic       freeze_q;

  sw_event_filter #(
    .LOCKOUT_TICKS (LOCKOUT_TICKS)
  ) u_event_filter (
    .clk_ms         (clk_ms),
    .reset_n        (reset_n),
    .tick           (bus.tick),
    .btn_start_stop (bus.btn_start_stop),
    .btn_lap_reset  (bus.btn_lap_reset),
    .ss_evt         (ss_evt),
    .lr_evt         (lr_evt)
  );

  always_comb begin
    state_d   = state_q;
    lap_cnt_d = lap_cnt_q;
    clear_d   = 1'b0;
    cap_d     = 1'b0;
    case (state_q)
      // lap/reset in IDLE only consumes a lockout period.
      ST_IDLE: begin
        if (ss_evt) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ss_evt) begin
          state_d = ST_STOP;
        end else if (lr_evt) begin
          state_d   = ST_LAP;
          cap_d     = 1'b1;
          lap_cnt_d = lap_count_inc(lap_cnt_q);
        end
      end
      ST_LAP: begin
        if (ss_evt)      state_d = ST_STOP;
        else if (lr_evt) state_d = ST_RUN;
      end
      ST_STOP: begin
        if (ss_evt) begin
          state_d = ST_RUN;
        end else if (lr_evt) begin
          state_d   = ST_IDLE;
          clear_d   = 1'b1;
          lap_cnt_d = 4'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_ms or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      lap_cnt_q <= 4'd0;
      clear_q   <= 1'b0;
      cap_q     <= 1'b0;
      run_q     <= 1'b0;
      freeze_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lap_cnt_q <= lap_cnt_d;
      clear_q   <= clear_d;
      cap_q     <= cap_d;
      // The counter keeps running while a lap value is frozen on the display.
      run_q     <= (state_d == ST_RUN) || (state_d == ST_LAP);
      freeze_q  <= (state_d == ST_LAP);
    end
  end

  assign bus.state       = state_q;
  assign bus.lap_count   = lap_cnt_q;
  assign bus.clear       = clear_q;
  assign bus.lap_capture = cap_q;
  assign bus.run         = run_q;
  assign bus.freeze      = freeze_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed scoreboard bench for stopwatch_controller (LOCKOUT_TICKS = 20).
// Expected output vectors {state, run, freeze, clear, lap_capture, lap_count}
// are queued when a step is driven and popped when the DUT result is sampled.
module tb_stopwatch_controller;
  import stopwatch_controller_pkg::*;

  logic clk_ms = 1'b0;
  logic reset_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cnt;

  logic [9:0] exp_q[$];
  string      tag_q[$];
  logic [9:0] obs;

  always #5 clk_ms = ~clk_ms;

  stopwatch_controller_if bus ();

  stopwatch_controller #(
    .LOCKOUT_TICKS (8'd20)
  ) dut (
    .clk_ms  (clk_ms),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign obs = {bus.state, bus.run, bus.freeze, bus.clear, bus.lap_capture, bus.lap_count};

  function automatic logic [9:0] vec(input logic [1:0] st, input logic r, input logic f,
                                     input logic c, input logic cap, input logic [3:0] n);
    return {st, r, f, c, cap, n};
  endfunction

  task automatic step();
    @(posedge clk_ms);
    #1;
  endtask

  task automatic push(input string tag, input logic [9:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [9:0] e;
    string      t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_chk++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", t, obs, e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      step();
    end
  endtask

  // Buttons high for exactly one sampled edge, then released.
  task automatic press(input logic ss, input logic lr, input string tag, input logic [9:0] e);
    bus.btn_start_stop = ss;
    bus.btn_lap_reset  = lr;
    push(tag, e);
    step();
    check_out();
    bus.btn_start_stop = 1'b0;
    bus.btn_lap_reset  = 1'b0;
  endtask

  initial begin
    reset_n            = 1'b1;
    bus.tick           = 1'b0;
    bus.btn_start_stop = 1'b0;
    bus.btn_lap_reset  = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    push("reset_async", vec(ST_IDLE, 0, 0, 0, 0, 0));
    check_out();
    step();
    step();
    reset_n = 1'b1;
    push("reset_idle", vec(ST_IDLE, 0, 0, 0, 0, 0));
    step();
    check_out();

    press(1, 0, "start", vec(ST_RUN, 1, 0, 0, 0, 0));
    push("start_no_clear", vec(ST_RUN, 1, 0, 0, 0, 0));
    step();
    check_out();
    ticks(25);
    push("run_steady", vec(ST_RUN, 1, 0, 0, 0, 0));
    check_out();

    press(0, 1, "lap1", vec(ST_LAP, 1, 1, 0, 1, 1));
    push("lap1_pulse_end", vec(ST_LAP, 1, 1, 0, 0, 1));
    step();
    check_out();
    ticks(25);
    press(0, 1, "lap_resume", vec(ST_RUN, 1, 0, 0, 0, 1));

    ticks(25);
    press(1, 0, "stop1", vec(ST_STOP, 0, 0, 0, 0, 1));
    ticks(25);
    press(1, 0, "restart", vec(ST_RUN, 1, 0, 0, 0, 1));
    ticks(10);
    press(1, 0, "lockout_ignored", vec(ST_RUN, 1, 0, 0, 0, 1));
    ticks(21);
    press(1, 0, "lockout_expired", vec(ST_STOP, 0, 0, 0, 0, 1));

    ticks(25);
    press(0, 1, "clear", vec(ST_IDLE, 0, 0, 1, 0, 0));
    push("clear_one_cycle", vec(ST_IDLE, 0, 0, 0, 0, 0));
    step();
    check_out();

    ticks(25);
    press(0, 1, "idle_lap_reset", vec(ST_IDLE, 0, 0, 0, 0, 0));
    ticks(5);
    press(1, 0, "idle_lr_lockout", vec(ST_IDLE, 0, 0, 0, 0, 0));
    ticks(20);
    press(1, 0, "start2", vec(ST_RUN, 1, 0, 0, 0, 0));

    ticks(25);
    press(0, 1, "lap_a", vec(ST_LAP, 1, 1, 0, 1, 1));
    ticks(25);
    press(0, 1, "resume_a", vec(ST_RUN, 1, 0, 0, 0, 1));
    ticks(25);
    press(1, 1, "both_buttons", vec(ST_STOP, 0, 0, 0, 0, 1));
    push("both_no_capture", vec(ST_STOP, 0, 0, 0, 0, 1));
    step();
    check_out();

    ticks(25);
    bus.btn_start_stop = 1'b1;
    push("hold_start", vec(ST_RUN, 1, 0, 0, 0, 1));
    step();
    check_out();
    ticks(25);
    push("hold_single_event", vec(ST_RUN, 1, 0, 0, 0, 1));
    step();
    check_out();
    bus.btn_start_stop = 1'b0;

    cnt = 1;
    for (int i = 0; i < 16; i++) begin
      ticks(25);
      if (cnt < 15) cnt++;
      press(0, 1, "lap_sat", vec(ST_LAP, 1, 1, 0, 1, 4'(cnt)));
      if (i < 15) begin
        ticks(25);
        press(0, 1, "lap_back", vec(ST_RUN, 1, 0, 0, 0, 4'(cnt)));
      end
    end
    push("lap_count_15", vec(ST_LAP, 1, 1, 0, 0, 15));
    step();
    check_out();

    ticks(3);
    @(negedge clk_ms);
    reset_n = 1'b0;
    #1;
    push("async_reset_midlock", vec(ST_IDLE, 0, 0, 0, 0, 0));
    check_out();
    bus.btn_start_stop = 1'b1;
    step();
    push("reset_held", vec(ST_IDLE, 0, 0, 0, 0, 0));
    check_out();
    reset_n = 1'b1;
    push("first_edge_event", vec(ST_RUN, 1, 0, 0, 0, 0));
    step();
    check_out();
    bus.btn_start_stop = 1'b0;
    push("post_reset_steady", vec(ST_RUN, 1, 0, 0, 0, 0));
    step();
    check_out();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
